timer_dev: RTL and testbench

TIMER_DEV -- requirements
Module: timer_dev

---
 rtl/timer_dev.sv | 178 +++++++++++++++++
 tb/tb_timer_dev.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_dev.sv
`default_nettype none
// ============================================================================
//  Module      : timer_dev
//  Description : Memory-mapped 32-bit down-counting timer with one-shot and
//                auto-reload modes and a maskable interrupt request.
//                Register map (word select Addr = bus address bits [3:2]):
//                  0 CTRL   : [0] Enable, [2:1] Mode, [3] IM, [31:4] read 0
//                  1 PRESET : 32-bit read/write reload value
//                  2 COUNT  : 32-bit read-only current count
//                  3 unused : reads 0, writes ignored
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_dev (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        We,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        IRQ
);

    // ------------------------------------------------------------------------
    // Register addresses and mode encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] c_ADDR_PRESET = 2'd1;
    localparam logic [1:0] c_ADDR_COUNT  = 2'd2;
    localparam logic [1:0] c_MODE_RELOAD = 2'd1;

    // ------------------------------------------------------------------------
    // Controller states
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------------
    state_t      state_q,  state_d;
    logic [3:0]  ctrl_q,   ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q,  count_d;
    logic        irq_q,    irq_d;

    // ------------------------------------------------------------------------
    // Decoded bus writes and FSM side-effect strobes
    // ------------------------------------------------------------------------
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_enable;
    logic [1:0]  w_mode;
    logic        w_irq_set;     // counter expired this edge
    logic        w_irq_hw_clr;  // auto-reload drops the flag after one cycle
    logic        w_en_hw_clr;   // one-shot clears Enable on expiry

    assign w_wr_ctrl   = We && (Addr == c_ADDR_CTRL);
    assign w_wr_preset = We && (Addr == c_ADDR_PRESET);
    assign w_enable    = ctrl_q[0];
    assign w_mode      = ctrl_q[2:1];

    // State register and all datapath registers; reset dominates any write
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    // Next-state logic: sequencing, counting and expiry handling
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        w_irq_set    = 1'b0;
        w_irq_hw_clr = 1'b0;
        w_en_hw_clr  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_enable) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                // PRESET is sampled only here, so writes while counting
                // take effect on the next period.
                count_d = preset_q;
                state_d = S_CNT;
            end

            S_CNT: begin
                if (!w_enable) begin
                    // Stop and hold the current count; a later enable
                    // restarts from PRESET via LOAD.
                    state_d = S_IDLE;
                end else if (count_q != 32'd0) begin
                    count_d = count_q - 32'd1;
                end else begin
                    state_d   = S_INT;
                    w_irq_set = 1'b1;
                end
            end

            S_INT: begin
                if (w_mode == c_MODE_RELOAD) begin
                    w_irq_hw_clr = 1'b1;
                    state_d      = S_LOAD;
                end else begin
                    // Modes 0, 2 and 3 are one-shot.
                    w_en_hw_clr = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // CTRL update: a CPU write on the same edge beats the hardware Enable clear
    always_comb begin
        ctrl_d = ctrl_q;
        if (w_wr_ctrl) begin
            ctrl_d = data_in[3:0];
        end else if (w_en_hw_clr) begin
            ctrl_d = {ctrl_q[3:1], 1'b0};
        end
    end

    // PRESET update from the bus
    always_comb begin
        preset_d = preset_q;
        if (w_wr_preset) begin
            preset_d = data_in;
        end
    end

    // Interrupt flag: expiry sets it; a CTRL/PRESET write or auto-reload clears it
    always_comb begin
        irq_d = irq_q;
        if (w_irq_set) begin
            irq_d = 1'b1;
        end else if (w_wr_ctrl || w_wr_preset || w_irq_hw_clr) begin
            irq_d = 1'b0;
        end
    end

    // Combinational read mux
    always_comb begin
        data_out = 32'd0;
        case (Addr)
            c_ADDR_CTRL:   data_out = {28'd0, ctrl_q};
            c_ADDR_PRESET: data_out = preset_q;
            c_ADDR_COUNT:  data_out = count_q;
            default:       data_out = 32'd0;
        endcase
    end

    // Interrupt output gated by the mask bit
    assign IRQ = irq_q & ctrl_q[3];

endmodule
`default_nettype wire

// File: tb/tb_timer_dev.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_dev
//  Description : Directed self-checking bench for timer_dev.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_dev;

    logic        clk;
    logic        reset;
    logic [1:0]  Addr;
    logic        We;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    timer_dev u_dut (
        .clk      (clk),
        .reset    (reset),
        .Addr     (Addr),
        .We       (We),
        .data_in  (data_in),
        .data_out (data_out),
        .IRQ      (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Bus write taking effect on the next rising edge
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr    = a;
        data_in = d;
        We      = 1'b1;
        tick();
        We      = 1'b0;
        data_in = 32'd0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        Addr = a;
        #1;
        chk(tag, data_out, exp);
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        chk(tag, {31'd0, IRQ}, {31'd0, exp});
    endtask

    // Safety net against a stuck simulation
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [31:0] exp_cnt;
        int p;

        reset   = 1'b1;
        We      = 1'b0;
        Addr    = 2'd0;
        data_in = 32'd0;

        // Reset overriding a simultaneous write
        Addr    = 2'd1;
        data_in = 32'hFFFF_FFFF;
        We      = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        We      = 1'b0;
        data_in = 32'd0;
        rd(2'd0, 32'd0, "rst_ctrl");
        rd(2'd1, 32'd0, "rst_preset");
        rd(2'd2, 32'd0, "rst_count");
        rd(2'd3, 32'd0, "rst_unused");
        chk_irq(1'b0, "rst_irq");

        // ---------------- One-shot, PRESET=5 ----------------
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);                 // edge E0
        tick();                          // E1
        tick();                          // E2
        rd(2'd2, 32'd5, "os_count_e2");
        repeat (5) tick();               // E7
        rd(2'd2, 32'd0, "os_count_e7");
        chk_irq(1'b0, "os_irq_e7");
        tick();                          // E8
        chk_irq(1'b1, "os_irq_e8");
        tick();                          // E9
        rd(2'd0, 32'h8, "os_ctrl_e9");
        chk_irq(1'b1, "os_irq_e9");
        repeat (4) tick();
        chk_irq(1'b1, "os_irq_hold");
        wr(2'd0, 32'h8);
        chk_irq(1'b0, "os_irq_clr");

        // ---------------- Auto-reload, PRESET=2 ----------------
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);                 // edge E0
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k >= 2) begin
                p = (k - 2) % 5;
                exp_cnt = (p == 0) ? 32'd2 : (p == 1) ? 32'd1 : 32'd0;
                rd(2'd2, exp_cnt, $sformatf("ar_count_e%0d", k));
                chk_irq(p == 3, $sformatf("ar_irq_e%0d", k));
            end
        end
        wr(2'd0, 32'h0);                 // lands in LOAD: count 2, then stops
        repeat (3) tick();
        rd(2'd2, 32'd2, "ar_stop_count");
        chk_irq(1'b0, "ar_stop_irq");

        // ---------------- Mask, PRESET=1 ----------------
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_irq(1'b0, $sformatf("mask_irq_e%0d", k));
        end
        rd(2'd0, 32'h0, "mask_ctrl_done");
        wr(2'd0, 32'h1);                 // E0
        tick();                          // E1
        wr(2'd0, 32'h9);                 // E2, before expiry
        chk_irq(1'b0, "unmask_e2");
        tick();                          // E3
        chk_irq(1'b0, "unmask_e3");
        tick();                          // E4
        chk_irq(1'b1, "unmask_e4");
        wr(2'd0, 32'h0);
        chk_irq(1'b0, "unmask_clr");

        // ---------------- Disable mid-count, PRESET=100 ----------------
        wr(2'd1, 32'd100);
        wr(2'd0, 32'h9);
        n = 0;
        Addr = 2'd2;
        #1;
        while (data_out !== 32'd41 && n < 300) begin
            tick();
            n++;
        end
        chk("dis_reach41", {31'd0, n < 300}, 32'd1);
        wr(2'd0, 32'h0);                 // this edge yields 40, then stops
        rd(2'd2, 32'd40, "dis_count40");
        repeat (5) tick();
        rd(2'd2, 32'd40, "dis_hold40");
        chk_irq(1'b0, "dis_irq");

        // Bus: COUNT and unused address are not writable
        wr(2'd2, 32'h1234);
        rd(2'd2, 32'd40, "bus_wr_count");
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd2, 32'd40, "bus_wr_unused_cnt");
        rd(2'd3, 32'd0, "bus_rd_unused");
        rd(2'd1, 32'd100, "bus_preset");

        // Re-enable restarts from PRESET
        wr(2'd0, 32'h9);                 // E0
        tick();                          // E1
        tick();                          // E2
        rd(2'd2, 32'd100, "reload100");
        // PRESET write while counting does not disturb COUNT
        wr(2'd1, 32'd7);
        rd(2'd2, 32'd99, "pre_wr_cnt99");
        rd(2'd1, 32'd7, "pre_wr_preset");
        tick();
        rd(2'd2, 32'd98, "pre_wr_cnt98");
        wr(2'd0, 32'h0);
        repeat (2) tick();

        // ---------------- PRESET=0 one-shot ----------------
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);                 // E0
        tick();
        chk_irq(1'b0, "p0_irq_e1");
        tick();
        chk_irq(1'b0, "p0_irq_e2");
        tick();
        chk_irq(1'b1, "p0_irq_e3");
        // CPU CTRL write on the hardware Enable-clear edge wins
        wr(2'd0, 32'h9);                 // E4
        rd(2'd0, 32'h9, "race_ctrl");
        chk_irq(1'b0, "race_irq");
        repeat (3) tick();               // E7: expires again
        chk_irq(1'b1, "race_irq_again");

        // ---------------- Reset while IRQ=1 ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_irq(1'b0, "rst2_irq");
        rd(2'd0, 32'd0, "rst2_ctrl");
        rd(2'd1, 32'd0, "rst2_preset");
        rd(2'd2, 32'd0, "rst2_count");
        repeat (4) tick();
        rd(2'd2, 32'd0, "rst2_idle_count");
        chk_irq(1'b0, "rst2_idle_irq");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
